// File: rtl/enemy_life_ctrl.sv
// enemy_life_ctrl: per-enemy health, stagger, death/respawn and contact-attack controller.
//
// Ports:
//   Clk                        system clock (only clock)
//   Reset                      synchronous, active-high
//   game_frame_clk_rising_edge one-cycle frame strobe
//   Bullet_Hit                 one-cycle hit pulse
//   Bullet_Damage[2:0]         damage of the hit (0 counts as 1)
//   Enemy_Attack_Ready         enemy is touching the player
//   Game_Over                  freezes all state while high
//   is_alive                   enemy is alive (ALIVE or STAGGER)
//   Enemy_Is_Attacked          knock-back request latch
//   Health[3:0]                current health
//   Player_Damage_Pulse        one-cycle pulse, player loses 1 health
//   Kill_Pulse                 one-cycle pulse on entry to DEAD
module enemy_life_ctrl #(
    parameter int unsigned MAX_HEALTH     = 5,
    parameter int unsigned HIT_FRAMES     = 6,
    parameter int unsigned RESPAWN_FRAMES = 120,
    parameter int unsigned ATTACK_PERIOD  = 30
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       game_frame_clk_rising_edge,
    input  logic       Bullet_Hit,
    input  logic [2:0] Bullet_Damage,
    input  logic       Enemy_Attack_Ready,
    input  logic       Game_Over,
    output logic       is_alive,
    output logic       Enemy_Is_Attacked,
    output logic [3:0] Health,
    output logic       Player_Damage_Pulse,
    output logic       Kill_Pulse
);

    localparam logic [1:0] StAlive   = 2'd0;
    localparam logic [1:0] StStagger = 2'd1;
    localparam logic [1:0] StDead    = 2'd2;

    localparam logic [3:0] HealthInit  = 4'(MAX_HEALTH);
    localparam logic [7:0] HitLast     = 8'(HIT_FRAMES);
    localparam logic [7:0] RespawnLast = 8'(RESPAWN_FRAMES);
    localparam logic [7:0] CdReload    = 8'(ATTACK_PERIOD - 1);

    logic [1:0] state_q, state_d;
    logic [3:0] health_q, health_d;
    logic [7:0] cd_q, cd_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic       attacked_q, attacked_d;
    logic       dmg_pulse_q, dmg_pulse_d;
    logic       kill_pulse_q, kill_pulse_d;

    logic [3:0] eff_dmg;
    logic [3:0] health_hit;
    logic [7:0] frame_inc;
    logic       strobe;

    assign strobe     = game_frame_clk_rising_edge;
    assign eff_dmg    = (Bullet_Damage == 3'd0) ? 4'd1 : {1'b0, Bullet_Damage};
    assign health_hit = (health_q > eff_dmg) ? (health_q - eff_dmg) : 4'd0;
    assign frame_inc  = frame_cnt_q + 8'd1;

    always_comb begin
        state_d      = state_q;
        health_d     = health_q;
        cd_d         = cd_q;
        frame_cnt_d  = frame_cnt_q;
        attacked_d   = attacked_q;
        dmg_pulse_d  = 1'b0;
        kill_pulse_d = 1'b0;

        if (!Game_Over) begin
            // Latch drops once the enemy block has seen it on one frame strobe.
            if (strobe && attacked_q) begin
                attacked_d = 1'b0;
            end

            case (state_q)
                StAlive: begin
                    if (Bullet_Hit) begin
                        // The hit wins over a coincident strobe: no count, no attack.
                        health_d    = health_hit;
                        cd_d        = CdReload;
                        frame_cnt_d = 8'd0;
                        if (health_hit == 4'd0) begin
                            state_d      = StDead;
                            attacked_d   = 1'b0;
                            kill_pulse_d = 1'b1;
                        end else begin
                            state_d    = StStagger;
                            attacked_d = 1'b1;
                        end
                    end else if (strobe) begin
                        frame_cnt_d = frame_inc;
                        if (Enemy_Attack_Ready) begin
                            if (cd_q == 8'd0) begin
                                dmg_pulse_d = 1'b1;
                                cd_d        = CdReload;
                            end else begin
                                cd_d = cd_q - 8'd1;
                            end
                        end
                    end
                end

                StStagger: begin
                    if (Bullet_Hit && (health_hit == 4'd0)) begin
                        state_d      = StDead;
                        health_d     = 4'd0;
                        cd_d         = CdReload;
                        frame_cnt_d  = 8'd0;
                        attacked_d   = 1'b0;
                        kill_pulse_d = 1'b1;
                    end else begin
                        // Non-lethal hits neither restart the stagger nor re-arm the latch.
                        if (Bullet_Hit) begin
                            health_d = health_hit;
                        end
                        if (strobe) begin
                            if (frame_inc == HitLast) begin
                                state_d     = StAlive;
                                frame_cnt_d = 8'd0;
                            end else begin
                                frame_cnt_d = frame_inc;
                            end
                        end
                    end
                end

                StDead: begin
                    if (strobe) begin
                        if (frame_inc == RespawnLast) begin
                            state_d     = StAlive;
                            health_d    = HealthInit;
                            frame_cnt_d = 8'd0;
                        end else begin
                            frame_cnt_d = frame_inc;
                        end
                    end
                end

                default: begin
                    state_d     = StAlive;
                    frame_cnt_d = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= StAlive;
            health_q     <= HealthInit;
            cd_q         <= 8'd0;
            frame_cnt_q  <= 8'd0;
            attacked_q   <= 1'b0;
            dmg_pulse_q  <= 1'b0;
            kill_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            health_q     <= health_d;
            cd_q         <= cd_d;
            frame_cnt_q  <= frame_cnt_d;
            attacked_q   <= attacked_d;
            dmg_pulse_q  <= dmg_pulse_d;
            kill_pulse_q <= kill_pulse_d;
        end
    end

    assign is_alive            = (state_q != StDead);
    assign Enemy_Is_Attacked   = attacked_q;
    assign Health              = health_q;
    assign Player_Damage_Pulse = dmg_pulse_q;
    assign Kill_Pulse          = kill_pulse_q;

endmodule

// File: tb/tb_enemy_life_ctrl.sv
// tb_enemy_life_ctrl: directed stimulus for enemy_life_ctrl with a queue-based scoreboard.
// Stimulus pushes expected snapshots/pulses tagged with a cycle index; the monitor pops them.
module tb_enemy_life_ctrl;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       game_frame_clk_rising_edge = 1'b0;
    logic       Bullet_Hit = 1'b0;
    logic [2:0] Bullet_Damage = 3'd0;
    logic       Enemy_Attack_Ready = 1'b0;
    logic       Game_Over = 1'b0;
    logic       is_alive;
    logic       Enemy_Is_Attacked;
    logic [3:0] Health;
    logic       Player_Damage_Pulse;
    logic       Kill_Pulse;

    enemy_life_ctrl dut (
        .Clk                        (Clk),
        .Reset                      (Reset),
        .game_frame_clk_rising_edge (game_frame_clk_rising_edge),
        .Bullet_Hit                 (Bullet_Hit),
        .Bullet_Damage              (Bullet_Damage),
        .Enemy_Attack_Ready         (Enemy_Attack_Ready),
        .Game_Over                  (Game_Over),
        .is_alive                   (is_alive),
        .Enemy_Is_Attacked          (Enemy_Is_Attacked),
        .Health                     (Health),
        .Player_Damage_Pulse        (Player_Damage_Pulse),
        .Kill_Pulse                 (Kill_Pulse)
    );

    always #10 Clk = ~Clk;

    int cyc = 0;
    int last = 0;
    int checks = 0;
    int errors = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    // Expected snapshots: {is_alive, Enemy_Is_Attacked, Health}
    int         snap_at[$];
    string      snap_name[$];
    logic [5:0] snap_exp[$];
    // Expected pulses: kind 0 = player damage, 1 = kill
    int         pls_at[$];
    string      pls_name[$];
    bit         pls_kind[$];

    task automatic drive(input logic rst, input logic hit, input logic [2:0] dmg,
                         input logic rdy, input logic strb, input logic go);
        Reset                      = rst;
        Bullet_Hit                 = hit;
        Bullet_Damage              = dmg;
        Enemy_Attack_Ready         = rdy;
        game_frame_clk_rising_edge = strb;
        Game_Over                  = go;
        @(posedge Clk);
        #1;
        last = cyc;
    endtask

    task automatic strobe(input logic rdy, input logic go);
        drive(1'b0, 1'b0, 3'd0, rdy, 1'b1, go);
    endtask

    task automatic idle(input logic rdy, input logic go);
        drive(1'b0, 1'b0, 3'd0, rdy, 1'b0, go);
    endtask

    task automatic snap(input string name, input logic alive, input logic att,
                        input logic [3:0] h);
        snap_at.push_back(last);
        snap_name.push_back(name);
        snap_exp.push_back({alive, att, h});
    endtask

    task automatic pulse(input bit kind, input string name);
        pls_at.push_back(last);
        pls_name.push_back(name);
        pls_kind.push_back(kind);
    endtask

    // Monitor: compares whatever the DUT presents against the queued expectations.
    always @(negedge Clk) begin
        while (snap_at.size() > 0 && snap_at[0] <= cyc) begin
            int         at;
            string      nm;
            logic [5:0] ex;
            at = snap_at.pop_front();
            nm = snap_name.pop_front();
            ex = snap_exp.pop_front();
            checks++;
            if (at != cyc || {is_alive, Enemy_Is_Attacked, Health} !== ex) begin
                errors++;
                $display("FAIL %s @%0d: got alive=%0b att=%0b health=%0d, want alive=%0b att=%0b health=%0d",
                         nm, cyc, is_alive, Enemy_Is_Attacked, Health, ex[5], ex[4], ex[3:0]);
            end
        end
        while (pls_at.size() > 0 && pls_at[0] < cyc) begin
            checks++;
            errors++;
            $display("FAIL %s: got no pulse at cycle %0d, want kind=%0d pulse", pls_name[0],
                     pls_at[0], pls_kind[0]);
            void'(pls_at.pop_front());
            void'(pls_name.pop_front());
            void'(pls_kind.pop_front());
        end
        if (Player_Damage_Pulse === 1'b1) begin
            checks++;
            if (pls_at.size() > 0 && pls_at[0] == cyc && pls_kind[0] == 1'b0) begin
                void'(pls_at.pop_front());
                void'(pls_name.pop_front());
                void'(pls_kind.pop_front());
            end else begin
                errors++;
                $display("FAIL dmg_pulse @%0d: got Player_Damage_Pulse=1, want 0", cyc);
            end
        end
        if (Kill_Pulse === 1'b1) begin
            checks++;
            if (pls_at.size() > 0 && pls_at[0] == cyc && pls_kind[0] == 1'b1) begin
                void'(pls_at.pop_front());
                void'(pls_name.pop_front());
                void'(pls_kind.pop_front());
            end else begin
                errors++;
                $display("FAIL kill_pulse @%0d: got Kill_Pulse=1, want 0", cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    int atk_at[3] = '{1, 31, 61};

    initial begin
        int ai;

        // 1: reset, single hit dmg=2, latch timing, stagger length of 6 strobes
        drive(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        snap("reset", 1'b1, 1'b0, 4'd5);
        drive(1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
        snap("hit2", 1'b1, 1'b1, 4'd3);
        idle(1'b0, 1'b0);
        snap("att_hold", 1'b1, 1'b1, 4'd3);
        strobe(1'b0, 1'b0);
        snap("att_clear", 1'b1, 1'b0, 4'd3);
        idle(1'b0, 1'b0);
        for (int k = 2; k <= 5; k++) begin
            strobe(1'b0, 1'b0);
            idle(1'b0, 1'b0);
        end
        // Still staggered: a hit must not re-arm the latch
        drive(1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
        snap("stagger_hit", 1'b1, 1'b0, 4'd2);
        strobe(1'b0, 1'b0);
        snap("stagger_end", 1'b1, 1'b0, 4'd2);
        // Back in ALIVE: a hit re-enters STAGGER and sets the latch
        drive(1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
        snap("restagger", 1'b1, 1'b1, 4'd1);
        for (int k = 1; k <= 6; k++) begin
            strobe(1'b0, 1'b0);
            idle(1'b0, 1'b0);
        end

        // 2: kill from STAGGER, hits ignored while dead, respawn after 120 strobes
        drive(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        snap("reset2", 1'b1, 1'b0, 4'd5);
        drive(1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
        snap("hit3", 1'b1, 1'b1, 4'd2);
        drive(1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0);
        snap("kill", 1'b0, 1'b0, 4'd0);
        pulse(1'b1, "kill_stagger");
        for (int k = 1; k <= 120; k++) begin
            strobe(1'b0, 1'b0);
            if (k == 119) snap("dead_119", 1'b0, 1'b0, 4'd0);
            if (k == 120) snap("respawn", 1'b1, 1'b0, 4'd5);
            if (k == 10) begin
                drive(1'b0, 1'b1, 3'd7, 1'b1, 1'b0, 1'b0);
                snap("dead_hit", 1'b0, 1'b0, 4'd0);
            end else begin
                idle(1'b0, 1'b0);
            end
        end

        // 3: continuous contact for 65 strobes
        drive(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        snap("reset3", 1'b1, 1'b0, 4'd5);
        ai = 0;
        for (int k = 1; k <= 65; k++) begin
            strobe(1'b1, 1'b0);
            if (ai < 3 && k == atk_at[ai]) begin
                pulse(1'b0, $sformatf("attack_%0d", k));
                ai++;
            end
            idle(1'b1, 1'b0);
        end
        snap("attack_end", 1'b1, 1'b0, 4'd5);

        // 4: dmg=0 counts as 1; hit on a strobe does not count that strobe or attack
        drive(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0);
        snap("dmg0_on_strobe", 1'b1, 1'b1, 4'd4);
        idle(1'b0, 1'b0);
        strobe(1'b0, 1'b0);
        snap("att_first_sample", 1'b1, 1'b0, 4'd4);
        idle(1'b0, 1'b0);
        for (int k = 2; k <= 5; k++) begin
            strobe(1'b0, 1'b0);
            idle(1'b0, 1'b0);
        end
        drive(1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
        snap("still_stagger", 1'b1, 1'b0, 4'd3);
        strobe(1'b0, 1'b0);
        drive(1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
        snap("alive_after_6", 1'b1, 1'b1, 4'd2);

        // 5: Game_Over freeze while dead, then finish respawn
        drive(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0);
        snap("kill_alive", 1'b0, 1'b0, 4'd0);
        pulse(1'b1, "kill_from_alive");
        for (int k = 1; k <= 10; k++) begin
            strobe(1'b0, 1'b0);
            idle(1'b0, 1'b0);
        end
        for (int k = 1; k <= 50; k++) begin
            strobe(k[0], 1'b1);
            drive(1'b0, 1'b1, 3'd3, ~k[0], 1'b0, 1'b1);
            snap("game_over_frozen", 1'b0, 1'b0, 4'd0);
        end
        for (int k = 1; k <= 110; k++) begin
            strobe(1'b0, 1'b0);
            if (k == 109) snap("dead_after_go", 1'b0, 1'b0, 4'd0);
            if (k == 110) snap("respawn_after_go", 1'b1, 1'b0, 4'd5);
            idle(1'b0, 1'b0);
        end
        drive(1'b0, 1'b1, 3'd1, 1'b1, 1'b1, 1'b1);
        snap("go_alive_hit", 1'b1, 1'b0, 4'd5);

        // 6: reset while staggered, then Game_Over blocks an attack that fires once released
        drive(1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
        snap("stagger_pre_rst", 1'b1, 1'b1, 4'd4);
        drive(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        snap("rst_in_stagger", 1'b1, 1'b0, 4'd5);
        strobe(1'b1, 1'b1);
        snap("go_no_attack", 1'b1, 1'b0, 4'd5);
        strobe(1'b1, 1'b0);
        pulse(1'b0, "attack_after_rst");
        snap("post_rst_attack", 1'b1, 1'b0, 4'd5);

        for (int k = 0; k < 4; k++) idle(1'b0, 1'b0);

        while (snap_at.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got unchecked snapshot, want checked", snap_name[0]);
            void'(snap_at.pop_front());
            void'(snap_name.pop_front());
            void'(snap_exp.pop_front());
        end
        while (pls_at.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got no pulse, want pulse at %0d", pls_name[0], pls_at[0]);
            void'(pls_at.pop_front());
            void'(pls_name.pop_front());
            void'(pls_kind.pop_front());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
